// File: rtl/ir_rx_frontend.sv
`timescale 1ns/1ps
// ir_rx_frontend
// Input conditioning between the raw IR receiver pin and the NEC decoder.
// The pin is optionally inverted and then synchronised. Any new level must be
// observed for FILT consecutive synchronised samples before the filtered output
// follows it. A pulse that reverts earlier is discarded and counted as a glitch.
// Both directions see the same latency (SYNC_STAGES + FILT cycles), so the pulse
// widths seen by the decoder match the widths on the pin.
//
// Ports
//   clk_1m      in   1  1 MHz clock, sole clock domain
//   rst_n       in   1  synchronous active-low reset
//   ir_pin      in   1  raw receiver output, asynchronous, idle high
//   glitch_clr  in   1  synchronous clear of glitch_cnt (wins over an increment)
//   ir          out  1  filtered level, idle high
//   ir_rise     out  1  one-cycle strobe in the cycle ir goes 0->1
//   ir_fall     out  1  one-cycle strobe in the cycle ir goes 1->0
//   idle        out  1  high once ir has not toggled for IDLE cycles
//   glitch_cnt  out  8  rejected pulses, saturating at 255
module ir_rx_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT        = 100,
  parameter int unsigned IDLE        = 12000,
  parameter int unsigned INVERT      = 0
) (
  input  logic       clk_1m,
  input  logic       rst_n,
  input  logic       ir_pin,
  input  logic       glitch_clr,
  output logic       ir,
  output logic       ir_rise,
  output logic       ir_fall,
  output logic       idle,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned FW = $clog2(FILT + 1);
  localparam int unsigned IW = $clog2(IDLE + 1);
  localparam logic [FW-1:0] FILT_C = FW'(FILT);
  localparam logic [IW-1:0] IDLE_C = IW'(IDLE);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHANGE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   pin_s;
  logic                   samp_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [FW-1:0]          filt_r;
  logic [FW-1:0]          filt_nxt_s;
  logic                   accept_s;
  logic                   glitch_s;

  logic                   ir_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   idle_r;
  logic [IW-1:0]          idle_cnt_r;
  logic [IW-1:0]          idle_cnt_nxt_s;
  logic [7:0]             glitch_cnt_r;
  logic [7:0]             glitch_cnt_nxt_s;

  assign pin_s  = (INVERT != 0) ? ~ir_pin : ir_pin;
  assign samp_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain; resets to the idle-high level of the receiver.
  always_ff @(posedge clk_1m) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin_s};
    end
  end

  // Qualification FSM state and sample counter.
  always_ff @(posedge clk_1m) begin
    if (!rst_n) begin
      state_r <= ST_STABLE;
      filt_r  <= {FW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      filt_r  <= filt_nxt_s;
    end
  end

  // Next-state logic. filt_r counts how many consecutive synchronised samples
  // have differed from ir so far; the change is accepted on the FILT-th one.
  always_comb begin
    state_nxt_s = state_r;
    filt_nxt_s  = filt_r;
    accept_s    = 1'b0;
    glitch_s    = 1'b0;
    case (state_r)
      ST_STABLE: begin
        if (samp_s != ir_r) begin
          if (FILT_C == FW'(1)) begin
            accept_s = 1'b1;
          end else begin
            state_nxt_s = ST_CHANGE;
            filt_nxt_s  = FW'(1);
          end
        end else begin
          filt_nxt_s = {FW{1'b0}};
        end
      end
      ST_CHANGE: begin
        if (samp_s == ir_r) begin
          // Pulse reverted before it was qualified.
          glitch_s    = 1'b1;
          state_nxt_s = ST_STABLE;
          filt_nxt_s  = {FW{1'b0}};
        end else if (filt_r == (FILT_C - FW'(1))) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_STABLE;
          filt_nxt_s  = {FW{1'b0}};
        end else begin
          filt_nxt_s = filt_r + FW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_STABLE;
        filt_nxt_s  = {FW{1'b0}};
      end
    endcase
  end

  // Idle counter restarts on every accepted edge and saturates at IDLE.
  always_comb begin
    idle_cnt_nxt_s = idle_cnt_r;
    if (accept_s) begin
      idle_cnt_nxt_s = {IW{1'b0}};
    end else if (idle_cnt_r != IDLE_C) begin
      idle_cnt_nxt_s = idle_cnt_r + IW'(1);
    end else begin
      idle_cnt_nxt_s = idle_cnt_r;
    end
  end

  // Glitch counter: clear has priority, increments saturate at 255.
  always_comb begin
    glitch_cnt_nxt_s = glitch_cnt_r;
    if (glitch_clr) begin
      glitch_cnt_nxt_s = 8'd0;
    end else if (glitch_s && (glitch_cnt_r != 8'hFF)) begin
      glitch_cnt_nxt_s = glitch_cnt_r + 8'd1;
    end else begin
      glitch_cnt_nxt_s = glitch_cnt_r;
    end
  end

  // Registered outputs; the strobes and the idle drop coincide with the ir change.
  always_ff @(posedge clk_1m) begin
    if (!rst_n) begin
      ir_r         <= 1'b1;
      rise_r       <= 1'b0;
      fall_r       <= 1'b0;
      idle_cnt_r   <= IDLE_C;
      idle_r       <= 1'b1;
      glitch_cnt_r <= 8'd0;
    end else begin
      ir_r         <= accept_s ? samp_s : ir_r;
      rise_r       <= accept_s & samp_s;
      fall_r       <= accept_s & ~samp_s;
      idle_cnt_r   <= idle_cnt_nxt_s;
      idle_r       <= (idle_cnt_nxt_s == IDLE_C);
      glitch_cnt_r <= glitch_cnt_nxt_s;
    end
  end

  assign ir         = ir_r;
  assign ir_rise    = rise_r;
  assign ir_fall    = fall_r;
  assign idle       = idle_r;
  assign glitch_cnt = glitch_cnt_r;

endmodule

// File: tb/tb_ir_rx_frontend.sv
`timescale 1ns/1ps
// Bench for ir_rx_frontend. Two instances share the stimulus: one with the
// default polarity, one with INVERT=1 driven by the complemented pin; both must
// match the same reference model every cycle.
module tb_ir_rx_frontend;

  localparam int IDLE_T = 12000;

  logic       clk_1m = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir_pin = 1'b1;
  logic       glitch_clr = 1'b0;
  logic       pin_n;
  logic       a_ir, a_rise, a_fall, a_idle;
  logic       b_ir, b_rise, b_fall, b_idle;
  logic [7:0] a_cnt, b_cnt;
  logic [11:0] a_v, b_v;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  bit m_ir, m_rise, m_fall, m_idle, m_glitch;
  int m_since, m_cnt;
  bit q[$];

  assign pin_n = ~ir_pin;
  assign a_v = {a_ir, a_rise, a_fall, a_idle, a_cnt};
  assign b_v = {b_ir, b_rise, b_fall, b_idle, b_cnt};

  always #5 clk_1m = ~clk_1m;

  ir_rx_frontend dut_a (
    .clk_1m(clk_1m), .rst_n(rst_n), .ir_pin(ir_pin), .glitch_clr(glitch_clr),
    .ir(a_ir), .ir_rise(a_rise), .ir_fall(a_fall), .idle(a_idle), .glitch_cnt(a_cnt)
  );

  ir_rx_frontend #(.INVERT(1)) dut_b (
    .clk_1m(clk_1m), .rst_n(rst_n), .ir_pin(pin_n), .glitch_clr(glitch_clr),
    .ir(b_ir), .ir_rise(b_rise), .ir_fall(b_fall), .idle(b_idle), .glitch_cnt(b_cnt)
  );

  function automatic logic [11:0] model_vec();
    return {m_ir, m_rise, m_fall, m_idle, 8'(m_cnt)};
  endfunction

  // Reference model, evaluated once per rising edge using the inputs that edge saw.
  // q holds the pin samples; the newest two are still inside the synchroniser.
  // ir flips when the 100 most recent visible samples all differ from it; a
  // glitch is a run of differing samples that ends before reaching 100.
  task automatic model_step();
    bit all_diff;
    int n;
    cyc++;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_glitch = 1'b0;
    if (!rst_n) begin
      q.delete();
      q.push_back(1'b1);
      q.push_back(1'b1);
      m_ir = 1'b1;
      m_since = IDLE_T;
      m_idle = 1'b1;
      m_cnt = 0;
    end else begin
      n = q.size();
      all_diff = (n >= 101);
      if (all_diff) begin
        for (int i = 2; i <= 101; i++) if (q[n-i] == m_ir) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_ir = ~m_ir;
        m_rise = m_ir;
        m_fall = ~m_ir;
        m_since = 0;
      end else begin
        if (m_since < IDLE_T) m_since++;
        if (n >= 3 && q[n-2] == m_ir && q[n-3] != m_ir) m_glitch = 1'b1;
      end
      if (glitch_clr) m_cnt = 0;
      else if (m_glitch && m_cnt < 255) m_cnt++;
      m_idle = (m_since == IDLE_T);
      q.push_back(ir_pin);
      if (q.size() > 128) q.pop_front();
    end
  endtask

  task automatic cycle();
    @(negedge clk_1m);
    model_step();
  endtask

  task automatic test_reset();
    int rel, tf;
    bit idle_at_fall;
    rst_n = 1'b0;
    ir_pin = 1'b0;
    glitch_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (a_v !== 12'h900 || b_v !== 12'h900) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, 12'h900);
      end
    end
    rel = cyc;
    rst_n = 1'b1;
    tf = -1;
    idle_at_fall = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      checks++;
      if (a_v !== model_vec() || b_v !== model_vec()) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, model_vec());
      end
      if (a_fall === 1'b1 && tf < 0) begin
        tf = cyc;
        idle_at_fall = a_idle;
      end
    end
    checks++;
    if (tf - rel !== 102) begin
      failures++;
      $display("FAIL reset_fall_latency got=%0d exp=%0d", tf - rel, 102);
    end
    checks++;
    if (idle_at_fall !== 1'b0) begin
      failures++;
      $display("FAIL idle_drop_with_strobe got=%0b exp=0", idle_at_fall);
    end
  endtask

  task automatic test_fall_rise();
    int t0, t1, tf, tr, nf, nr;
    ir_pin = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      checks++;
      if (a_v !== model_vec() || b_v !== model_vec()) begin
        failures++;
        $display("FAIL fr_settle cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, model_vec());
      end
    end
    t0 = cyc; ir_pin = 1'b0; tf = -1; tr = -1; nf = 0; nr = 0;
    for (int i = 0; i < 800; i++) begin
      if (i == 500) begin
        t1 = cyc;
        ir_pin = 1'b1;
      end
      cycle();
      checks++;
      if (a_v !== model_vec() || b_v !== model_vec()) begin
        failures++;
        $display("FAIL fr_cycle cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, model_vec());
      end
      if (a_fall === 1'b1) begin nf++; if (tf < 0) tf = cyc; end
      if (a_rise === 1'b1) begin nr++; if (tr < 0) tr = cyc; end
    end
    checks++;
    if (tf - t0 !== 102) begin failures++; $display("FAIL fall_latency got=%0d exp=102", tf - t0); end
    checks++;
    if (tr - t1 !== 102) begin failures++; $display("FAIL rise_latency got=%0d exp=102", tr - t1); end
    checks++;
    if (tr - tf !== 500) begin failures++; $display("FAIL low_width got=%0d exp=500", tr - tf); end
    checks++;
    if (nf !== 1 || nr !== 1) begin
      failures++;
      $display("FAIL strobe_count got=%0d/%0d exp=1/1", nf, nr);
    end
  endtask

  task automatic test_glitch();
    int lens[3] = '{50, 99, 100};
    int exp_cnt[3] = '{1, 2, 2};
    int exp_edges[3] = '{0, 0, 2};
    int edges;
    for (int p = 0; p < 3; p++) begin
      edges = 0;
      for (int i = 0; i < lens[p] + 250; i++) begin
        ir_pin = (i < lens[p]) ? 1'b0 : 1'b1;
        cycle();
        checks++;
        if (a_v !== model_vec() || b_v !== model_vec()) begin
          failures++;
          $display("FAIL glitch_cycle cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, model_vec());
        end
        if (a_rise === 1'b1 || a_fall === 1'b1) edges++;
      end
      checks++;
      if (a_cnt !== 8'(exp_cnt[p]) || edges !== exp_edges[p]) begin
        failures++;
        $display("FAIL glitch_len%0d got=cnt %0d edges %0d exp=cnt %0d edges %0d",
                 lens[p], a_cnt, edges, exp_cnt[p], exp_edges[p]);
      end
    end
  endtask

  task automatic test_saturate();
    for (int g = 0; g < 300; g++) begin
      for (int i = 0; i < 7; i++) begin
        ir_pin = (i < 3) ? 1'b0 : 1'b1;
        cycle();
        checks++;
        if (a_v !== model_vec() || b_v !== model_vec()) begin
          failures++;
          $display("FAIL sat_cycle cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, model_vec());
        end
      end
    end
    checks++;
    if (a_cnt !== 8'd255 || b_cnt !== 8'd255) begin
      failures++;
      $display("FAIL glitch_saturate got=%0d/%0d exp=255", a_cnt, b_cnt);
    end
  endtask

  task automatic test_clr_priority();
    ir_pin = 1'b0;
    repeat (5) cycle();
    ir_pin = 1'b1;
    repeat (2) cycle();
    // the reverted pulse is seen as a glitch on the next edge
    glitch_clr = 1'b1;
    cycle();
    glitch_clr = 1'b0;
    checks++;
    if (m_glitch !== 1'b1) begin
      failures++;
      $display("FAIL clr_alignment got=%0b exp=1", m_glitch);
    end
    checks++;
    if (a_cnt !== 8'd0 || b_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clr_priority got=%0d/%0d exp=0", a_cnt, b_cnt);
    end
    for (int i = 0; i < 13; i++) begin
      ir_pin = (i < 5) ? 1'b0 : 1'b1;
      cycle();
    end
    checks++;
    if (a_cnt !== 8'd1) begin
      failures++;
      $display("FAIL count_after_clr got=%0d exp=1", a_cnt);
    end
  endtask

  task automatic test_random();
    int len;
    bit lvl;
    lvl = 1'b0;
    for (int s = 0; s < 20; s++) begin
      len = $urandom_range(1, 220);
      ir_pin = lvl;
      for (int i = 0; i < len; i++) begin
        cycle();
        checks++;
        if (a_v !== model_vec() || b_v !== model_vec()) begin
          failures++;
          $display("FAIL random_cycle cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, model_vec());
        end
      end
      lvl = ~lvl;
    end
    ir_pin = 1'b1;
    repeat (250) cycle();
    checks++;
    if (a_ir !== 1'b1 || b_ir !== 1'b1) begin
      failures++;
      $display("FAIL random_settle got=%b%b exp=11", a_ir, b_ir);
    end
  endtask

  task automatic test_nec();
    int seg_len[$];
    bit seg_lvl[$];
    int e[$];
    int t0, idle_cyc;
    logic [31:0] frame;
    logic [31:0] word;
    frame = {8'hBA, 8'h45, 8'hFF, 8'h00};
    seg_len.push_back(9000); seg_lvl.push_back(1'b0);
    seg_len.push_back(4500); seg_lvl.push_back(1'b1);
    for (int i = 0; i < 32; i++) begin
      seg_len.push_back(560); seg_lvl.push_back(1'b0);
      seg_len.push_back(frame[i] ? 1690 : 560); seg_lvl.push_back(1'b1);
    end
    seg_len.push_back(560); seg_lvl.push_back(1'b0);
    t0 = cyc;
    idle_cyc = -1;
    for (int s = 0; s < seg_len.size(); s++) begin
      ir_pin = seg_lvl[s];
      for (int i = 0; i < seg_len[s]; i++) begin
        cycle();
        checks++;
        if (a_v !== model_vec() || b_v !== model_vec()) begin
          failures++;
          $display("FAIL nec_cycle cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, model_vec());
        end
        if (a_rise === 1'b1 || a_fall === 1'b1) e.push_back(cyc);
      end
    end
    ir_pin = 1'b1;
    for (int i = 0; i < 12200; i++) begin
      cycle();
      checks++;
      if (a_v !== model_vec() || b_v !== model_vec()) begin
        failures++;
        $display("FAIL nec_tail cyc=%0d got=%h inv=%h exp=%h", cyc, a_v, b_v, model_vec());
      end
      if (a_rise === 1'b1 || a_fall === 1'b1) e.push_back(cyc);
      if (a_idle === 1'b1 && idle_cyc < 0) idle_cyc = cyc;
    end
    checks++;
    if (e.size() !== 68) begin
      failures++;
      $display("FAIL nec_edge_count got=%0d exp=68", e.size());
    end else begin
      checks++;
      if (e[0] - t0 !== 102) begin
        failures++;
        $display("FAIL nec_latency got=%0d exp=102", e[0] - t0);
      end
      for (int j = 0; j < 67; j++) begin
        checks++;
        if (e[j+1] - e[j] !== seg_len[j]) begin
          failures++;
          $display("FAIL nec_width%0d got=%0d exp=%0d", j, e[j+1] - e[j], seg_len[j]);
        end
      end
      for (int i = 0; i < 32; i++) word[i] = ((e[4+2*i] - e[3+2*i]) > 1000);
      checks++;
      if (word[23:16] !== 8'h45 || word[31:24] !== ~word[23:16]) begin
        failures++;
        $display("FAIL nec_decode got=%h exp=%h", word, 32'hBA45FF00);
      end
      checks++;
      if (idle_cyc - e[67] !== IDLE_T) begin
        failures++;
        $display("FAIL nec_idle_rise got=%0d exp=%0d", idle_cyc - e[67], IDLE_T);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall_rise();
    test_glitch();
    test_saturate();
    test_clr_priority();
    test_random();
    test_nec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
